stopwatch_watch_cu: RTL and testbench

Control and timekeeping core that consumes the single-cycle button pulses produced by the debounced button controller. It runs a stopwatch (STOP/RUN/CLEAR state machine with a centisecond..hour counter chain) and a free-running wall-clock watch whose second/minute/hour fields are adjusted by button pulses. It sits between the button controller and the display driver and exposes both time sets as registered values.

---
 rtl/stopwatch_watch_cu.sv | 177 +++++++++++++++++
 tb/tb_stopwatch_watch_cu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_watch_cu.sv
// stopwatch_watch_cu
// Control and timekeeping core between the button controller and the display
// driver. Runs a stopwatch (STOP/RUN/CLEAR) and a free-running wall-clock watch,
// both as cs/sec/min/hour counter chains advanced by a centisecond tick.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low
//   sw_mode    0: run/clear active, 1: sec/min/hour active
//   run/clear  single-cycle stopwatch pulses
//   sec/min/hour  single-cycle watch field increment pulses
//   sw_running 1 while stopwatch is in RUN
//   sch_*      stopwatch time (cs 7b, sec 6b, min 6b, hour 5b)
//   wch_*      watch time     (cs 7b, sec 6b, min 6b, hour 5b)
//
// state   | meaning
// --------+---------------------------------------------------------
// S_STOP  | stopwatch halted, divider and time frozen
// S_RUN   | divider counting, time advances on each tick
// S_CLEAR | single cycle, zero divider and stopwatch time
module stopwatch_watch_cu #(
   parameter int TICK_DIV      = 1_000_000,
   parameter int WCH_HOUR_INIT = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sw_mode,
   input  logic       run,
   input  logic       clear,
   input  logic       sec,
   input  logic       min,
   input  logic       hour,
   output logic       sw_running,
   output logic [6:0] sch_cs,
   output logic [5:0] sch_sec,
   output logic [5:0] sch_min,
   output logic [4:0] sch_hour,
   output logic [6:0] wch_cs,
   output logic [5:0] wch_sec,
   output logic [5:0] wch_min,
   output logic [4:0] wch_hour
);

   localparam int DIV_W = $clog2(TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {S_STOP, S_RUN, S_CLEAR} state_t;

   typedef struct packed {
      logic [4:0] hour;
      logic [5:0] min;
      logic [5:0] sec;
      logic [6:0] cs;
   } tod_t;

   localparam tod_t WCH_RESET = '{hour: 5'(WCH_HOUR_INIT), min: 6'd0, sec: 6'd0, cs: 7'd0};

   function automatic tod_t tod_tick(input tod_t t);
      tod_t n;
      n = t;
      if (t.cs != 7'd99) begin
         n.cs = t.cs + 7'd1;
      end else begin
         n.cs = 7'd0;
         if (t.sec != 6'd59) begin
            n.sec = t.sec + 6'd1;
         end else begin
            n.sec = 6'd0;
            if (t.min != 6'd59) begin
               n.min = t.min + 6'd1;
            end else begin
               n.min  = 6'd0;
               n.hour = (t.hour == 5'd23) ? 5'd0 : t.hour + 5'd1;
            end
         end
      end
      return n;
   endfunction

   state_t           state_q, state_d;
   logic             sw_running_q, sw_running_d;
   logic [DIV_W-1:0] sw_div_q, sw_div_d;
   logic [DIV_W-1:0] wch_div_q, wch_div_d;
   logic             pend_q, pend_d;
   tod_t             sch_q, sch_d;
   tod_t             wch_q, wch_d;

   logic run_g, clear_g, sec_g, min_g, hour_g;
   logic adj, wch_tick, wch_due;

   assign run_g   = run   & ~sw_mode;
   assign clear_g = clear & ~sw_mode;
   assign sec_g   = sec   &  sw_mode;
   assign min_g   = min   &  sw_mode;
   assign hour_g  = hour  &  sw_mode;

   always_comb begin
      state_d  = state_q;
      sw_div_d = sw_div_q;
      sch_d    = sch_q;
      case (state_q)
         S_STOP: begin
            if (clear_g) begin
               state_d = S_CLEAR;
            end else if (run_g) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (run_g) begin
               state_d = S_STOP;
            end
            if (sw_div_q == DIV_LAST) begin
               sw_div_d = '0;
               sch_d    = tod_tick(sch_q);
            end else begin
               sw_div_d = sw_div_q + DIV_W'(1);
            end
         end
         S_CLEAR: begin
            state_d  = S_STOP;
            sw_div_d = '0;
            sch_d    = '0;
         end
         default: state_d = S_STOP;
      endcase
      sw_running_d = (state_d == S_RUN);
   end

   // An adjust wins the cycle; a coincident tick waits one cycle in pend_q.
   always_comb begin
      wch_tick  = (wch_div_q == DIV_LAST);
      wch_div_d = wch_tick ? '0 : wch_div_q + DIV_W'(1);
      adj       = sec_g | min_g | hour_g;
      wch_due   = wch_tick | pend_q;
      pend_d    = adj & wch_due;
      wch_d     = wch_q;
      if (adj) begin
         if (sec_g)  wch_d.sec  = (wch_q.sec  == 6'd59) ? 6'd0 : wch_q.sec  + 6'd1;
         if (min_g)  wch_d.min  = (wch_q.min  == 6'd59) ? 6'd0 : wch_q.min  + 6'd1;
         if (hour_g) wch_d.hour = (wch_q.hour == 5'd23) ? 5'd0 : wch_q.hour + 5'd1;
      end else if (wch_due) begin
         wch_d = tod_tick(wch_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_STOP;
         sw_running_q <= 1'b0;
         sw_div_q     <= '0;
         wch_div_q    <= '0;
         pend_q       <= 1'b0;
         sch_q        <= '0;
         wch_q        <= WCH_RESET;
      end else begin
         state_q      <= state_d;
         sw_running_q <= sw_running_d;
         sw_div_q     <= sw_div_d;
         wch_div_q    <= wch_div_d;
         pend_q       <= pend_d;
         sch_q        <= sch_d;
         wch_q        <= wch_d;
      end
   end

   assign sw_running = sw_running_q;
   assign sch_cs     = sch_q.cs;
   assign sch_sec    = sch_q.sec;
   assign sch_min    = sch_q.min;
   assign sch_hour   = sch_q.hour;
   assign wch_cs     = wch_q.cs;
   assign wch_sec    = wch_q.sec;
   assign wch_min    = wch_q.min;
   assign wch_hour   = wch_q.hour;

endmodule

// File: tb/tb_stopwatch_watch_cu.sv
module tb_stopwatch_watch_cu;

   localparam int TD  = 4;
   localparam int DAY = 8_640_000;
   localparam logic [4:0] P_RUN  = 5'b10000;
   localparam logic [4:0] P_CLR  = 5'b01000;
   localparam logic [4:0] P_SEC  = 5'b00100;
   localparam logic [4:0] P_MIN  = 5'b00010;
   localparam logic [4:0] P_HOUR = 5'b00001;

   logic       clk;
   logic       reset;
   logic       sw_mode, run, clear, sec, min, hour;
   logic       sw_running;
   logic [6:0] sch_cs, wch_cs;
   logic [5:0] sch_sec, sch_min, wch_sec, wch_min;
   logic [4:0] sch_hour, wch_hour;

   int n_chk  = 0;
   int n_fail = 0;

   stopwatch_watch_cu #(.TICK_DIV(TD), .WCH_HOUR_INIT(12)) dut (
      .clk(clk), .reset(reset), .sw_mode(sw_mode),
      .run(run), .clear(clear), .sec(sec), .min(min), .hour(hour),
      .sw_running(sw_running),
      .sch_cs(sch_cs), .sch_sec(sch_sec), .sch_min(sch_min), .sch_hour(sch_hour),
      .wch_cs(wch_cs), .wch_sec(wch_sec), .wch_min(wch_min), .wch_hour(wch_hour)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: times held as total centiseconds of the day.
   int sw_cnt, sw_ph, w_cnt, w_ph;
   bit sw_run_m, sw_clr_m, w_pend;
   logic run_g, clear_g, adj_g, w_tick;

   assign run_g   = run & ~sw_mode;
   assign clear_g = clear & ~sw_mode;
   assign adj_g   = sw_mode & (sec | min | hour);
   assign w_tick  = (w_ph == TD - 1);

   function automatic int adj_watch(input int t, input bit s, input bit m, input bit h);
      int cs_v, se, mi, hr;
      cs_v = t % 100;
      se   = (t / 100) % 60;
      mi   = (t / 6000) % 60;
      hr   = t / 360000;
      if (s) se = (se + 1) % 60;
      if (m) mi = (mi + 1) % 60;
      if (h) hr = (hr + 1) % 24;
      return cs_v + 100 * se + 6000 * mi + 360000 * hr;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_cnt   <= 0;
         sw_ph    <= 0;
         sw_run_m <= 1'b0;
         sw_clr_m <= 1'b0;
         w_cnt    <= 12 * 360000;
         w_ph     <= 0;
         w_pend   <= 1'b0;
      end else begin
         if (sw_clr_m) begin
            sw_cnt   <= 0;
            sw_ph    <= 0;
            sw_clr_m <= 1'b0;
         end else if (sw_run_m) begin
            sw_ph <= (sw_ph + 1) % TD;
            if (sw_ph == TD - 1) sw_cnt <= (sw_cnt + 1) % DAY;
            if (run_g) sw_run_m <= 1'b0;
         end else if (clear_g) begin
            sw_clr_m <= 1'b1;
         end else if (run_g) begin
            sw_run_m <= 1'b1;
         end
         w_ph <= (w_ph + 1) % TD;
         if (adj_g) begin
            w_cnt  <= adj_watch(w_cnt, sec, min, hour);
            w_pend <= w_tick | w_pend;
         end else begin
            if (w_tick || w_pend) w_cnt <= (w_cnt + 1) % DAY;
            w_pend <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("sw_running", sw_running, sw_run_m);
      chk("sch_cs",   sch_cs,   sw_cnt % 100);
      chk("sch_sec",  sch_sec,  (sw_cnt / 100) % 60);
      chk("sch_min",  sch_min,  (sw_cnt / 6000) % 60);
      chk("sch_hour", sch_hour, sw_cnt / 360000);
      chk("wch_cs",   wch_cs,   w_cnt % 100);
      chk("wch_sec",  wch_sec,  (w_cnt / 100) % 60);
      chk("wch_min",  wch_min,  (w_cnt / 6000) % 60);
      chk("wch_hour", wch_hour, w_cnt / 360000);
   end

   task automatic pulse(input logic [4:0] m);
      @(posedge clk); #1;
      {run, clear, sec, min, hour} = m;
      @(posedge clk); #1;
      {run, clear, sec, min, hour} = 5'b0;
   endtask

   initial begin
      bit   done;
      int   hv, cv;
      logic [4:0] m;
      logic [6:0] prev;

      reset = 1'b0;
      sw_mode = 1'b0;
      {run, clear, sec, min, hour} = 5'b0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_sw_running", sw_running, 0);
      chk("rst_sch_cs", sch_cs, 0);
      chk("rst_sch_hour", sch_hour, 0);
      chk("rst_wch_hour", wch_hour, 12);
      chk("rst_wch_cs", wch_cs, 0);

      @(posedge clk); #1 reset = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("idle40_wch_cs", wch_cs, 10);
      chk("idle40_sch_cs", sch_cs, 0);

      // stopwatch: 400 RUN cycles = 100 ticks
      pulse(P_RUN);
      @(negedge clk);
      chk("run_sw_running", sw_running, 1);
      repeat (398) @(posedge clk);
      pulse(P_RUN);
      @(negedge clk);
      chk("stop_sch_sec", sch_sec, 1);
      chk("stop_sch_cs", sch_cs, 0);
      chk("stop_sw_running", sw_running, 0);
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("frozen_sch_sec", sch_sec, 1);
      chk("frozen_sch_cs", sch_cs, 0);

      // clear ignored in RUN, honoured in STOP, wins over run
      pulse(P_RUN);
      repeat (20) @(posedge clk);
      pulse(P_CLR);
      @(negedge clk);
      chk("clr_in_run_running", sw_running, 1);
      pulse(P_RUN);
      pulse(P_CLR);
      @(posedge clk);
      @(negedge clk);
      chk("clr_sch_cs", sch_cs, 0);
      chk("clr_sch_sec", sch_sec, 0);
      pulse(P_RUN | P_CLR);
      @(negedge clk);
      chk("runclr_running_a", sw_running, 0);
      @(negedge clk);
      chk("runclr_running_b", sw_running, 0);

      // watch: steer to 23:59:59.98
      @(posedge clk); #1 sw_mode = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 600 && !done; k++) begin
         @(negedge clk);
         if (wch_hour == 23 && wch_min == 59 && wch_sec == 59 && wch_cs == 98) begin
            done = 1'b1;
         end else begin
            m = 5'b0;
            if (wch_sec  != 6'd59) m = m | P_SEC;
            if (wch_min  != 6'd59) m = m | P_MIN;
            if (wch_hour != 5'd23) m = m | P_HOUR;
            if (m != 5'b0) pulse(m);
         end
      end
      chk("sync_235959_98_found", done, 1);
      done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         @(negedge clk);
         if (wch_cs != 7'd98) done = 1'b1;
      end
      chk("tick1_wch_cs", wch_cs, 99);
      chk("tick1_wch_sec", wch_sec, 59);
      chk("tick1_wch_hour", wch_hour, 23);
      done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         @(negedge clk);
         if (wch_cs != 7'd99) done = 1'b1;
      end
      chk("wrap_wch_cs", wch_cs, 0);
      chk("wrap_wch_sec", wch_sec, 0);
      chk("wrap_wch_min", wch_min, 0);
      chk("wrap_wch_hour", wch_hour, 0);

      // sec adjust at 59 wraps without carry
      for (int k = 0; k < 100 && wch_sec != 6'd59; k++) pulse(P_SEC);
      pulse(P_SEC);
      @(negedge clk);
      chk("secwrap_wch_sec", wch_sec, 0);
      chk("secwrap_wch_min", wch_min, 0);

      // hour pulse coincident with a watch tick
      @(negedge clk);
      prev = wch_cs;
      done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         @(negedge clk);
         if (wch_cs != prev) done = 1'b1;
      end
      chk("tick_edge_found", done, 1);
      hv = w_cnt / 360000;
      cv = w_cnt % 100;
      repeat (2) @(posedge clk);
      pulse(P_HOUR);
      @(negedge clk);
      chk("coll_hour_n1", wch_hour, (hv + 1) % 24);
      chk("coll_cs_n1", wch_cs, cv);
      @(negedge clk);
      chk("coll_cs_n2", wch_cs, (cv + 1) % 100);

      // gating by sw_mode
      pulse(P_RUN);
      @(negedge clk);
      chk("gated_run_running", sw_running, 0);
      @(posedge clk); #1 sw_mode = 1'b0;
      pulse(P_SEC | P_MIN | P_HOUR);
      repeat (4) @(posedge clk);

      // async reset mid-run at 00:00:05.37
      pulse(P_RUN);
      done = 1'b0;
      for (int k = 0; k < 3000 && !done; k++) begin
         @(negedge clk);
         if (sch_sec == 6'd5 && sch_cs == 7'd37) done = 1'b1;
      end
      chk("sw_537_reached", done, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_sw_running", sw_running, 0);
      chk("arst_sch_cs", sch_cs, 0);
      chk("arst_sch_sec", sch_sec, 0);
      chk("arst_wch_cs", wch_cs, 0);
      chk("arst_wch_min", wch_min, 0);
      chk("arst_wch_hour", wch_hour, 12);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
